alu_uop_decoder: RTL and testbench

//  Front-end for the ALU: consumes the LR35902 opcode byte stream, handles the 0xCB prefix and d8

---
 rtl/gb_alu_pkg.sv | 59 +++++
 rtl/alu_opcode_lut.sv | 58 +++++
 rtl/alu_uop_decoder.sv | 104 ++++++++++
 tb/tb_alu_uop_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gb_alu_pkg.sv
// Shared LR35902 ALU definitions: op codes, register indices, decoder states, micro-op payload.
package gb_alu_pkg;

  localparam logic [7:0] CB_PREFIX = 8'hCB;
  localparam logic [2:0] REG_A     = 3'b111;
  localparam logic [2:0] REG_HLM   = 3'b110;
  localparam logic [2:0] PAIR_HL   = 3'b010;

  // Base 8-bit arithmetic ops (opcode [5:3])
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  // CB rotate/shift ops (CB byte [5:3])
  localparam logic [2:0] OP_RLC  = 3'd0;
  localparam logic [2:0] OP_RRC  = 3'd1;
  localparam logic [2:0] OP_RL   = 3'd2;
  localparam logic [2:0] OP_RR   = 3'd3;
  localparam logic [2:0] OP_SLA  = 3'd4;
  localparam logic [2:0] OP_SRA  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_SRL  = 3'd7;

  // Misc class: accumulator adjust ops and CB bit ops
  localparam logic [2:0] OP_DAA = 3'd0;
  localparam logic [2:0] OP_CPL = 3'd1;
  localparam logic [2:0] OP_SCF = 3'd2;
  localparam logic [2:0] OP_CCF = 3'd3;
  localparam logic [2:0] OP_BIT = 3'd1;
  localparam logic [2:0] OP_RES = 3'd2;
  localparam logic [2:0] OP_SET = 3'd3;

  localparam logic [7:0] F_Z = 8'h80;
  localparam logic [7:0] F_N = 8'h40;
  localparam logic [7:0] F_H = 8'h20;
  localparam logic [7:0] F_C = 8'h10;

  typedef enum logic [1:0] {ST_OP, ST_CB, ST_IMM, ST_HOLD} state_t;
  typedef enum logic [1:0] {CLS_ALU, CLS_IMM, CLS_PREFIX, CLS_NONALU} cls_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] src;
    logic [2:0] dest;
    logic       size;
    logic       ext;
    logic       misc;
    logic       mem;
    logic       imm_en;
    logic [7:0] imm;
    logic       nonalu;
  } uop_t;

endpackage

// File: rtl/alu_opcode_lut.sv
// Combinational opcode table: maps one byte (base or CB page) to micro-op fields and a class.
module alu_opcode_lut
  import gb_alu_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic       is_cb,
  output uop_t       uop,
  output cls_t       cls
);

  always_comb begin
    uop = '0;
    cls = CLS_NONALU;
    if (is_cb) begin
      cls      = CLS_ALU;
      uop.ext  = 1'b1;
      uop.dest = opcode[2:0];
      if (opcode[7:6] == 2'b00) begin
        uop.op  = opcode[5:3];
        uop.src = opcode[2:0];
        uop.mem = (opcode[2:0] == REG_HLM);
      end else begin
        uop.misc = 1'b1;
        uop.op   = {1'b0, opcode[7:6]};
        uop.src  = opcode[5:3];
        uop.mem  = (opcode[5:3] == REG_HLM) || (opcode[2:0] == REG_HLM);
      end
    end else if (opcode == CB_PREFIX) begin
      cls = CLS_PREFIX;
    end else if (opcode[7:6] == 2'b10) begin
      cls      = CLS_ALU;
      uop.op   = opcode[5:3];
      uop.src  = opcode[2:0];
      uop.dest = REG_A;
      uop.mem  = (opcode[2:0] == REG_HLM);
    end else if ((opcode & 8'hC7) == 8'hC6) begin
      // d8 form: operand arrives in the following byte
      cls        = CLS_IMM;
      uop.op     = opcode[5:3];
      uop.dest   = REG_A;
      uop.imm_en = 1'b1;
    end else if ((opcode & 8'hE7) == 8'h27) begin
      cls      = CLS_ALU;
      uop.misc = 1'b1;
      uop.op   = {1'b0, opcode[4:3]};
    end else if ((opcode & 8'hCF) == 8'h09) begin
      cls      = CLS_ALU;
      uop.op   = OP_ADD;
      uop.size = 1'b1;
      uop.src  = {1'b0, opcode[5:4]};
      uop.dest = PAIR_HL;
    end else begin
      uop.nonalu = 1'b1;
      uop.imm    = opcode;
    end
  end

endmodule

// File: rtl/alu_uop_decoder.sv
// Byte-stream front-end for the ALU: tracks CB prefix / d8 context and registers one micro-op per instruction.
module alu_uop_decoder
  import gb_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       uop_valid,
  input  logic       uop_ready,
  output logic [2:0] uop_op,
  output logic [2:0] uop_src,
  output logic [2:0] uop_dest,
  output logic       uop_size,
  output logic       uop_ext,
  output logic       uop_misc,
  output logic       uop_mem,
  output logic       uop_imm_en,
  output logic [7:0] uop_imm,
  output logic       uop_nonalu
);

  state_t state;
  uop_t   uop_q;
  uop_t   ctx_q;
  uop_t   lut_uop;
  uop_t   imm_uop;
  cls_t   lut_cls;
  logic   accept;

  alu_opcode_lut u_lut (
    .opcode (byte_data),
    .is_cb  (state == ST_CB),
    .uop    (lut_uop),
    .cls    (lut_cls)
  );

  // A held uop blocks intake unless it drains this same cycle
  assign byte_ready = !rst && !flush && ((state != ST_HOLD) || uop_ready);
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    imm_uop     = ctx_q;
    imm_uop.imm = byte_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_OP;
      uop_q     <= '0;
      ctx_q     <= '0;
      uop_valid <= 1'b0;
    end else if (flush) begin
      state     <= ST_OP;
      uop_valid <= 1'b0;
    end else begin
      if (state == ST_HOLD && uop_ready) begin
        uop_valid <= 1'b0;
        state     <= ST_OP;
      end
      if (accept) begin
        unique case (state)
          ST_CB: begin
            uop_q     <= lut_uop;
            uop_valid <= 1'b1;
            state     <= ST_HOLD;
          end
          ST_IMM: begin
            uop_q     <= imm_uop;
            uop_valid <= 1'b1;
            state     <= ST_HOLD;
          end
          default: begin
            // ST_OP, or ST_HOLD draining back-to-back
            if (lut_cls == CLS_PREFIX) begin
              state <= ST_CB;
            end else if (lut_cls == CLS_IMM) begin
              ctx_q <= lut_uop;
              state <= ST_IMM;
            end else begin
              uop_q     <= lut_uop;
              uop_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end
        endcase
      end
    end
  end

  assign uop_op     = uop_q.op;
  assign uop_src    = uop_q.src;
  assign uop_dest   = uop_q.dest;
  assign uop_size   = uop_q.size;
  assign uop_ext    = uop_q.ext;
  assign uop_misc   = uop_q.misc;
  assign uop_mem    = uop_q.mem;
  assign uop_imm_en = uop_q.imm_en;
  assign uop_imm    = uop_q.imm;
  assign uop_nonalu = uop_q.nonalu;

endmodule

// File: tb/tb_alu_uop_decoder.sv
// Self-checking bench for alu_uop_decoder: directed scenarios plus randomized traffic vs. a transaction model.
module tb_alu_uop_decoder;
  import gb_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, flush, byte_valid, uop_ready;
  logic [7:0] byte_data;
  logic       byte_ready, uop_valid;
  logic [2:0] uop_op, uop_src, uop_dest;
  logic       uop_size, uop_ext, uop_misc, uop_mem, uop_imm_en, uop_nonalu;
  logic [7:0] uop_imm;

  int checks = 0;
  int errors = 0;

  // Reference model: pending-uop flag, expected uop, parse phase (0 opcode, 1 after CB, 2 awaiting d8)
  bit         m_hold;
  uop_t       m_uop;
  int         m_phase;
  logic [2:0] m_immop;

  alu_uop_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .uop_valid  (uop_valid),
    .uop_ready  (uop_ready),
    .uop_op     (uop_op),
    .uop_src    (uop_src),
    .uop_dest   (uop_dest),
    .uop_size   (uop_size),
    .uop_ext    (uop_ext),
    .uop_misc   (uop_misc),
    .uop_mem    (uop_mem),
    .uop_imm_en (uop_imm_en),
    .uop_imm    (uop_imm),
    .uop_nonalu (uop_nonalu)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic uop_t dut_uop();
    uop_t u;
    u.op = uop_op; u.src = uop_src; u.dest = uop_dest; u.size = uop_size;
    u.ext = uop_ext; u.misc = uop_misc; u.mem = uop_mem; u.imm_en = uop_imm_en;
    u.imm = uop_imm; u.nonalu = uop_nonalu;
    return u;
  endfunction

  function automatic bit is_imm_opcode(input logic [7:0] b);
    return b inside {8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE};
  endfunction

  // Instruction-level decode from the opcode map, using integer arithmetic on the byte value
  function automatic uop_t ref_decode(input logic [7:0] b, input bit cb);
    uop_t u;
    int v;
    int r;
    v = int'(b);
    r = v % 8;
    u = '0;
    if (cb) begin
      u.ext  = 1'b1;
      u.dest = 3'(r);
      if (v < 64) begin
        u.op  = 3'(v / 8);
        u.src = 3'(r);
        u.mem = (r == 6);
      end else begin
        u.misc = 1'b1;
        u.op   = 3'(v / 64);
        u.src  = 3'((v / 8) % 8);
        u.mem  = (r == 6) || (((v / 8) % 8) == 6);
      end
    end else if (v >= 128 && v < 192) begin
      u.op   = 3'((v - 128) / 8);
      u.src  = 3'(r);
      u.dest = 3'd7;
      u.mem  = (r == 6);
    end else if (v == 'h27 || v == 'h2F || v == 'h37 || v == 'h3F) begin
      u.misc = 1'b1;
      u.op   = 3'((v - 'h27) / 8);
    end else if (v == 'h09 || v == 'h19 || v == 'h29 || v == 'h39) begin
      u.size = 1'b1;
      u.src  = 3'(v / 16);
      u.dest = 3'd2;
    end else begin
      u.nonalu = 1'b1;
      u.imm    = b;
    end
    return u;
  endfunction

  // One clock: drive at negedge, compare outputs, advance the model at posedge
  task automatic step(input bit bv, input logic [7:0] bd, input bit ur, input bit fl, input bit rs);
    bit acc;
    @(negedge clk);
    rst = rs; flush = fl; byte_valid = bv; byte_data = bd; uop_ready = ur;
    if (rs) begin
      m_hold = 0; m_uop = '0; m_phase = 0;
    end
    #1;
    check("byte_ready", 32'(byte_ready), 32'(!rs && !fl && (!m_hold || ur)));
    check("uop_valid", 32'(uop_valid), 32'(m_hold));
    if (m_hold || rs) check("uop_fields", 32'(dut_uop()), 32'(m_uop));
    @(posedge clk);
    if (!rs) begin
      if (fl) begin
        m_hold = 0; m_phase = 0;
      end else begin
        acc = bv && (!m_hold || ur);
        if (m_hold && ur) m_hold = 0;
        if (acc) begin
          if (m_phase == 1) begin
            m_uop = ref_decode(bd, 1'b1); m_hold = 1; m_phase = 0;
          end else if (m_phase == 2) begin
            m_uop = '0; m_uop.op = m_immop; m_uop.dest = 3'd7;
            m_uop.imm_en = 1'b1; m_uop.imm = bd;
            m_hold = 1; m_phase = 0;
          end else if (bd == 8'hCB) begin
            m_phase = 1;
          end else if (is_imm_opcode(bd)) begin
            m_immop = 3'((int'(bd) - 'hC6) / 8); m_phase = 2;
          end else begin
            m_uop = ref_decode(bd, 1'b0); m_hold = 1;
          end
        end
      end
    end
  endtask

  // Called right after step(): checks the registered uop against spelled-out constants
  task automatic expect_uop(input string tag, input logic [2:0] op, input logic [2:0] src,
                            input logic [2:0] dest, input logic size, input logic ext,
                            input logic misc, input logic mem, input logic imm_en,
                            input logic [7:0] imm, input logic nonalu);
    uop_t e;
    #1;
    e.op = op; e.src = src; e.dest = dest; e.size = size; e.ext = ext; e.misc = misc;
    e.mem = mem; e.imm_en = imm_en; e.imm = imm; e.nonalu = nonalu;
    check({tag, "_valid"}, 32'(uop_valid), 32'd1);
    check(tag, 32'(dut_uop()), 32'(e));
  endtask

  initial begin
    logic [7:0] b;
    int         sel;
    rst = 1'b1; flush = 1'b0; byte_valid = 1'b0; byte_data = '0; uop_ready = 1'b0;
    m_hold = 0; m_uop = '0; m_phase = 0; m_immop = '0;

    step(0, 8'h00, 0, 0, 1);
    check("rst_outputs", 32'({uop_valid, dut_uop()}), 32'd0);
    step(0, 8'h00, 1, 0, 1);

    // T1 ADD A,B
    step(1, 8'h80, 1, 0, 0);
    expect_uop("t1_add", 3'b000, 3'b000, 3'b111, 0, 0, 0, 0, 0, 8'h00, 0);
    // T2 BIT 7,(HL)
    step(1, 8'hCB, 1, 0, 0);
    step(1, 8'h7E, 1, 0, 0);
    expect_uop("t2_bit", 3'b001, 3'b111, 3'b110, 0, 1, 1, 1, 0, 8'h00, 0);
    step(0, 8'h00, 1, 0, 0);
    // T3 CP d8 with a stalled consumer
    step(1, 8'hFE, 1, 0, 0);
    step(1, 8'h42, 0, 0, 0);
    expect_uop("t3_cp", 3'b111, 3'b000, 3'b111, 0, 0, 0, 0, 1, 8'h42, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h00, 0, 0, 0);
      expect_uop("t3_hold", 3'b111, 3'b000, 3'b111, 0, 0, 0, 0, 1, 8'h42, 0);
    end
    step(0, 8'h00, 1, 0, 0);
    // T4 back-to-back XOR A / CPL / ADD HL,HL
    step(1, 8'hAF, 1, 0, 0);
    expect_uop("t4_xor", 3'b101, 3'b111, 3'b111, 0, 0, 0, 0, 0, 8'h00, 0);
    step(1, 8'h2F, 1, 0, 0);
    expect_uop("t4_cpl", 3'b001, 3'b000, 3'b000, 0, 0, 1, 0, 0, 8'h00, 0);
    step(1, 8'h29, 1, 0, 0);
    expect_uop("t4_addhl", 3'b000, 3'b010, 3'b010, 1, 0, 0, 0, 0, 8'h00, 0);
    step(0, 8'h00, 1, 0, 0);
    // T5 flush discards a pending CB prefix
    step(1, 8'hCB, 1, 0, 0);
    step(1, 8'h11, 1, 1, 0);
    step(1, 8'h05, 1, 0, 0);
    expect_uop("t5_nonalu", 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 8'h05, 1);
    step(0, 8'h00, 1, 0, 0);
    // T6 reset while waiting for a d8
    step(1, 8'hD6, 1, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    check("t6_rst", 32'({uop_valid, dut_uop()}), 32'd0);
    step(1, 8'h90, 1, 0, 0);
    expect_uop("t6_sub", 3'b010, 3'b000, 3'b111, 0, 0, 0, 0, 0, 8'h00, 0);

    // Randomized traffic weighted toward prefixes, d8 forms and the 80-BF block
    for (int i = 0; i < 4000; i++) begin
      sel = int'($urandom_range(0, 9));
      b   = 8'($urandom);
      if (sel == 0) b = 8'hCB;
      else if (sel == 1) b = {2'b11, b[5:3], 3'b110};
      else if (sel <= 3) b = {2'b10, b[5:0]};
      step($urandom_range(0, 9) < 7, b, $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
    end
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
